// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
//
// Purpose:
//   Turns single commands from a simple valid/ready command port into single
//   AHB-Lite transfers (one NONSEQ address phase followed by one data phase).
//   A one-cycle response strobe reports read data and the slave error
//   response. Misaligned or illegal-size commands are answered with an error
//   strobe and never reach the bus. A sticky flag records any run of slave
//   wait states that reaches TIMEOUT cycles. The FSM keeps waiting when that
//   happens; it does not abort the transfer.
//
// Handshakes:
//   Command port: a command transfers on a rising HCLK edge where CMD_VALID
//   and CMD_READY are both high. CMD_READY is high only in IDLE. The command
//   fields must be stable while CMD_VALID is high. Response port: RSP_VALID is
//   a single-cycle strobe with no back-pressure. RSP_RDATA and RSP_ERROR are
//   meaningful only while RSP_VALID is high.
//
// Ports:
//   HCLK, HRESETN         clock, synchronous active-low reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_WRITE, CMD_ADDR   command direction and byte address
//   CMD_SIZE, CMD_WDATA   command size (0/1/2 = byte/half/word) and write data
//   RSP_VALID             one-cycle response strobe
//   RSP_RDATA, RSP_ERROR  response read data and error indication
//   TIMEOUT_FLAG          sticky wait-state overrun
//   HADDR .. HWDATA       AHB-Lite master outputs
//   HRDATA, HREADY, HRESP AHB-Lite slave inputs
//   DBG_STATE             current FSM state (IDLE=0, ADDR=1, DATA=2, REJ=3)
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master #(
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    // command port
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [2:0]        CMD_SIZE,
    input  logic [31:0]       CMD_WDATA,
    // response port
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              TIMEOUT_FLAG,
    // AHB-Lite master
    output logic [AWIDTH-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    // debug
    output logic [1:0]        DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_REJ  = 2'd3
    } state_t;

    localparam logic [1:0]  LP_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  LP_HTRANS_NONSEQ = 2'b10;
    localparam logic [16:0] LP_TIMEOUT       = 17'(TIMEOUT);

    state_t              r_state;
    logic [1:0]          r_htrans;
    logic [AWIDTH-1:0]   r_haddr;
    logic                r_hwrite;
    logic [2:0]          r_hsize;
    logic [31:0]         r_hwdata;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_error;
    logic                r_timeout_flag;
    logic [15:0]         r_wait_cnt;

    logic                w_accept;
    logic                w_misalign;
    logic [16:0]         w_cnt_next;
    logic                w_cnt_sat;
    logic                w_timeout_hit;

    assign w_accept = CMD_VALID && (r_state == S_IDLE);

    // Sizes above word are illegal on this 32-bit bus; half and word
    // accesses must be naturally aligned.
    assign w_misalign = (CMD_SIZE > 3'd2) ||
                        ((CMD_SIZE == 3'd1) && CMD_ADDR[0]) ||
                        ((CMD_SIZE == 3'd2) && (CMD_ADDR[1:0] != 2'b00));

    // The wait counter is one bit wider here, so the compare against TIMEOUT
    // is correct up to the full 16-bit range. The stored count saturates.
    assign w_cnt_next    = {1'b0, r_wait_cnt} + 17'd1;
    assign w_cnt_sat     = &r_wait_cnt;
    assign w_timeout_hit = (w_cnt_next >= LP_TIMEOUT);

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_state        <= S_IDLE;
            r_htrans       <= LP_HTRANS_IDLE;
            r_haddr        <= '0;
            r_hwrite       <= 1'b0;
            r_hsize        <= 3'b000;
            r_hwdata       <= 32'h0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 32'h0;
            r_rsp_error    <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_wait_cnt     <= 16'h0;
        end else begin
            // The response strobe lasts only one cycle unless a branch below
            // sets it again.
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // The command registers drive the bus directly. A
                        // rejected command also loads them, but HTRANS stays
                        // IDLE, so the slave ignores them.
                        r_haddr    <= CMD_ADDR;
                        r_hwrite   <= CMD_WRITE;
                        r_hsize    <= CMD_SIZE;
                        r_hwdata   <= CMD_WDATA;
                        r_wait_cnt <= 16'h0;
                        if (w_misalign) begin
                            r_state     <= S_REJ;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else begin
                            r_state  <= S_ADDR;
                            r_htrans <= LP_HTRANS_NONSEQ;
                        end
                    end
                end

                S_ADDR: begin
                    if (HREADY) begin
                        r_state    <= S_DATA;
                        r_htrans   <= LP_HTRANS_IDLE;
                        r_wait_cnt <= 16'h0;
                    end else begin
                        // Address-phase outputs hold while the bus is stalled.
                        if (!w_cnt_sat) begin
                            r_wait_cnt <= w_cnt_next[15:0];
                        end
                        if (w_timeout_hit) begin
                            r_timeout_flag <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (HREADY) begin
                        // An error response exits here like any other
                        // completion, so a two-cycle error ends the command
                        // without a retry.
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= HRESP;
                        r_rsp_rdata <= r_hwrite ? 32'h0 : HRDATA;
                        r_wait_cnt  <= 16'h0;
                    end else begin
                        if (!w_cnt_sat) begin
                            r_wait_cnt <= w_cnt_next[15:0];
                        end
                        if (w_timeout_hit) begin
                            r_timeout_flag <= 1'b1;
                        end
                    end
                end

                S_REJ: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_htrans <= LP_HTRANS_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY    = (r_state == S_IDLE);
    assign RSP_VALID    = r_rsp_valid;
    assign RSP_RDATA    = r_rsp_rdata;
    assign RSP_ERROR    = r_rsp_error;
    assign TIMEOUT_FLAG = r_timeout_flag;

    assign HADDR        = r_haddr;
    assign HTRANS       = r_htrans;
    assign HWRITE       = r_hwrite;
    assign HSIZE        = r_hsize;
    assign HWDATA       = r_hwdata;

    // Single, unlocked, privileged data accesses only.
    assign HBURST       = 3'b000;
    assign HMASTLOCK    = 1'b0;
    assign HPROT        = 4'b0011;

    assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_cmd_master
//
// Purpose:
//   Directed self-checking bench for ahb_lite_cmd_master. It plays the AHB
//   slave by driving HREADY, HRESP and HRDATA cycle by cycle. Inputs change
//   1 time unit after each rising edge. Outputs are sampled at the same
//   point, so each sample shows the state registered at the edge just taken.
//   The DUT is built with TIMEOUT=4 so that the wait-state overrun can be
//   reached in a short run.
// ---------------------------------------------------------------------------
module tb_ahb_lite_cmd_master;

    localparam int AW = 10;

    logic          HCLK;
    logic          HRESETN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WRITE;
    logic [AW-1:0] CMD_ADDR;
    logic [2:0]    CMD_SIZE;
    logic [31:0]   CMD_WDATA;
    logic          RSP_VALID;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERROR;
    logic          TIMEOUT_FLAG;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic          HMASTLOCK;
    logic [3:0]    HPROT;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic [1:0]    DBG_STATE;

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_cmd_master #(.AWIDTH(AW), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
        .TIMEOUT_FLAG(TIMEOUT_FLAG),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_SIZE  = size;
        CMD_WDATA = wdata;
    endtask

    task automatic idle_cmd();
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_SIZE  = 3'd0;
        CMD_WDATA = 32'h0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        HRESETN = 1'b0;
        idle_cmd();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        tick(); tick(); tick();
        n_checks++; if (HTRANS !== 2'b00) begin n_errors++; $display("FAIL rst_htrans got %0h exp 0", HTRANS); end
        n_checks++; if (HADDR !== 10'h000) begin n_errors++; $display("FAIL rst_haddr got %0h exp 0", HADDR); end
        n_checks++; if (HWDATA !== 32'h0) begin n_errors++; $display("FAIL rst_hwdata got %0h exp 0", HWDATA); end
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid got %0b exp 0", RSP_VALID); end
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_errors++; $display("FAIL rst_timeout got %0b exp 0", TIMEOUT_FLAG); end
        HRESETN = 1'b1;
        tick();
        n_checks++; if (CMD_READY !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready got %0b exp 1", CMD_READY); end
        n_checks++; if (HBURST !== 3'b000) begin n_errors++; $display("FAIL const_hburst got %0h exp 0", HBURST); end
        n_checks++; if (HMASTLOCK !== 1'b0) begin n_errors++; $display("FAIL const_hmastlock got %0b exp 0", HMASTLOCK); end
        n_checks++; if (HPROT !== 4'b0011) begin n_errors++; $display("FAIL const_hprot got %0h exp 3", HPROT); end
    endtask

    task automatic test_word_write();
        drive_cmd(1'b1, 10'h004, 3'd2, 32'hA5A5_1234);
        HREADY = 1'b1;
        tick();  // edge 0: accepted
        idle_cmd();
        n_checks++; if (HTRANS !== 2'b10) begin n_errors++; $display("FAIL ww_c1_htrans got %0h exp 2", HTRANS); end
        n_checks++; if (HWRITE !== 1'b1) begin n_errors++; $display("FAIL ww_c1_hwrite got %0b exp 1", HWRITE); end
        n_checks++; if (HSIZE !== 3'b010) begin n_errors++; $display("FAIL ww_c1_hsize got %0h exp 2", HSIZE); end
        n_checks++; if (HADDR !== 10'h004) begin n_errors++; $display("FAIL ww_c1_haddr got %0h exp 4", HADDR); end
        n_checks++; if (CMD_READY !== 1'b0) begin n_errors++; $display("FAIL ww_c1_cmd_ready got %0b exp 0", CMD_READY); end
        tick();
        n_checks++; if (HTRANS !== 2'b00) begin n_errors++; $display("FAIL ww_c2_htrans got %0h exp 0", HTRANS); end
        n_checks++; if (HWDATA !== 32'hA5A5_1234) begin n_errors++; $display("FAIL ww_c2_hwdata got %0h exp a5a51234", HWDATA); end
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL ww_c2_rsp_valid got %0b exp 0", RSP_VALID); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL ww_c3_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_ERROR !== 1'b0) begin n_errors++; $display("FAIL ww_c3_rsp_error got %0b exp 0", RSP_ERROR); end
        n_checks++; if (RSP_RDATA !== 32'h0) begin n_errors++; $display("FAIL ww_c3_rsp_rdata got %0h exp 0", RSP_RDATA); end
        n_checks++; if (CMD_READY !== 1'b1) begin n_errors++; $display("FAIL ww_c3_cmd_ready got %0b exp 1", CMD_READY); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL ww_c4_rsp_valid got %0b exp 0", RSP_VALID); end
    endtask

    task automatic test_half_read_wait();
        drive_cmd(1'b0, 10'h002, 3'd1, 32'h0);
        HREADY = 1'b1;
        tick();  // edge 0
        idle_cmd();
        n_checks++; if (HTRANS !== 2'b10) begin n_errors++; $display("FAIL hr_c1_htrans got %0h exp 2", HTRANS); end
        n_checks++; if (HSIZE !== 3'b001) begin n_errors++; $display("FAIL hr_c1_hsize got %0h exp 1", HSIZE); end
        n_checks++; if (HWRITE !== 1'b0) begin n_errors++; $display("FAIL hr_c1_hwrite got %0b exp 0", HWRITE); end
        tick();  // edge 1: into data phase
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL hr_wait%0d_rsp_valid got %0b exp 0", k, RSP_VALID); end
            n_checks++; if (HTRANS !== 2'b00) begin n_errors++; $display("FAIL hr_wait%0d_htrans got %0h exp 0", k, HTRANS); end
        end
        HREADY = 1'b1;
        HRDATA = 32'h0000_BEEF;
        tick();
        HRDATA = 32'h0;
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL hr_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_RDATA !== 32'h0000_BEEF) begin n_errors++; $display("FAIL hr_rsp_rdata got %0h exp beef", RSP_RDATA); end
        n_checks++; if (RSP_ERROR !== 1'b0) begin n_errors++; $display("FAIL hr_rsp_error got %0b exp 0", RSP_ERROR); end
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_errors++; $display("FAIL hr_timeout got %0b exp 0", TIMEOUT_FLAG); end
        tick();
    endtask

    task automatic test_misaligned();
        logic [AW-1:0] addr;
        logic [2:0]    size;
        int            nonseq_seen;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin addr = 10'h006; size = 3'd2; end
                1:       begin addr = 10'h003; size = 3'd1; end
                default: begin addr = 10'h000; size = 3'd3; end
            endcase
            nonseq_seen = 0;
            drive_cmd(1'b0, addr, size, 32'h0);
            HREADY = 1'b1;
            HRDATA = 32'h1234_5678;
            tick();
            idle_cmd();
            if (HTRANS !== 2'b00) nonseq_seen++;
            n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL mis%0d_rsp_valid got %0b exp 1", i, RSP_VALID); end
            n_checks++; if (RSP_ERROR !== 1'b1) begin n_errors++; $display("FAIL mis%0d_rsp_error got %0b exp 1", i, RSP_ERROR); end
            n_checks++; if (RSP_RDATA !== 32'h0) begin n_errors++; $display("FAIL mis%0d_rsp_rdata got %0h exp 0", i, RSP_RDATA); end
            n_checks++; if (CMD_READY !== 1'b0) begin n_errors++; $display("FAIL mis%0d_cmd_ready got %0b exp 0", i, CMD_READY); end
            tick();
            if (HTRANS !== 2'b00) nonseq_seen++;
            n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL mis%0d_rsp_drop got %0b exp 0", i, RSP_VALID); end
            tick();
            if (HTRANS !== 2'b00) nonseq_seen++;
            n_checks++; if (nonseq_seen !== 0) begin n_errors++; $display("FAIL mis%0d_htrans_active got %0d exp 0", i, nonseq_seen); end
            HRDATA = 32'h0;
        end
    endtask

    task automatic test_error_resp();
        int nonseq_seen;
        drive_cmd(1'b1, 10'h008, 3'd2, 32'h5555_AAAA);
        HREADY = 1'b1;
        tick();  // edge 0
        idle_cmd();
        n_checks++; if (HTRANS !== 2'b10) begin n_errors++; $display("FAIL er_c1_htrans got %0h exp 2", HTRANS); end
        tick();  // edge 1
        HRESP = 1'b1; HREADY = 1'b0;
        tick();  // first error cycle
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL er_first_rsp_valid got %0b exp 0", RSP_VALID); end
        HRESP = 1'b1; HREADY = 1'b1;
        tick();  // second error cycle completes
        HRESP = 1'b0;
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL er_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_ERROR !== 1'b1) begin n_errors++; $display("FAIL er_rsp_error got %0b exp 1", RSP_ERROR); end
        nonseq_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (HTRANS !== 2'b00) nonseq_seen++;
            tick();
        end
        n_checks++; if (nonseq_seen !== 0) begin n_errors++; $display("FAIL er_no_retry got %0d exp 0", nonseq_seen); end
    endtask

    task automatic test_back_to_back();
        drive_cmd(1'b0, 10'h010, 3'd2, 32'h0);
        HREADY = 1'b1;
        tick();  // edge 0: accept A
        idle_cmd();
        tick();  // edge 1
        HRDATA = 32'h1111_2222;
        tick();  // edge 2: A completes
        HRDATA = 32'h0;
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL b2b_a_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_RDATA !== 32'h1111_2222) begin n_errors++; $display("FAIL b2b_a_rdata got %0h exp 11112222", RSP_RDATA); end
        n_checks++; if (CMD_READY !== 1'b1) begin n_errors++; $display("FAIL b2b_a_cmd_ready got %0b exp 1", CMD_READY); end
        drive_cmd(1'b1, 10'h020, 3'd2, 32'hCAFE_F00D);
        tick();  // edge 3: accept B in the response cycle
        idle_cmd();
        n_checks++; if (HTRANS !== 2'b10) begin n_errors++; $display("FAIL b2b_b_htrans got %0h exp 2", HTRANS); end
        n_checks++; if (HADDR !== 10'h020) begin n_errors++; $display("FAIL b2b_b_haddr got %0h exp 20", HADDR); end
        n_checks++; if (HWRITE !== 1'b1) begin n_errors++; $display("FAIL b2b_b_hwrite got %0b exp 1", HWRITE); end
        tick();
        n_checks++; if (HWDATA !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL b2b_b_hwdata got %0h exp cafef00d", HWDATA); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL b2b_b_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_RDATA !== 32'h0) begin n_errors++; $display("FAIL b2b_b_rdata got %0h exp 0", RSP_RDATA); end
        tick();
    endtask

    task automatic test_timeout();
        logic exp_flag;
        drive_cmd(1'b0, 10'h00C, 3'd2, 32'h0);
        HREADY = 1'b1;
        tick();  // edge 0
        idle_cmd();
        tick();  // edge 1: into data phase
        HREADY = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_flag = (k >= 4);
            n_checks++; if (TIMEOUT_FLAG !== exp_flag) begin n_errors++; $display("FAIL to_wait%0d_flag got %0b exp %0b", k, TIMEOUT_FLAG, exp_flag); end
            n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL to_wait%0d_rsp_valid got %0b exp 0", k, RSP_VALID); end
        end
        HREADY = 1'b1;
        HRDATA = 32'h0F0F_0F0F;
        tick();
        HRDATA = 32'h0;
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL to_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_RDATA !== 32'h0F0F_0F0F) begin n_errors++; $display("FAIL to_rsp_rdata got %0h exp f0f0f0f", RSP_RDATA); end
        n_checks++; if (RSP_ERROR !== 1'b0) begin n_errors++; $display("FAIL to_rsp_error got %0b exp 0", RSP_ERROR); end
        tick(); tick();
        n_checks++; if (TIMEOUT_FLAG !== 1'b1) begin n_errors++; $display("FAIL to_sticky got %0b exp 1", TIMEOUT_FLAG); end
    endtask

    task automatic test_reset_mid();
        drive_cmd(1'b0, 10'h014, 3'd2, 32'hDEAD_BEEF);
        HREADY = 1'b1;
        tick();  // edge 0
        idle_cmd();
        tick();  // edge 1: into data phase
        HREADY = 1'b0;
        tick();
        n_checks++; if (DBG_STATE !== 2'd2) begin n_errors++; $display("FAIL rm_in_data got %0d exp 2", DBG_STATE); end
        HRESETN = 1'b0;
        tick();
        n_checks++; if (HTRANS !== 2'b00) begin n_errors++; $display("FAIL rm_htrans got %0h exp 0", HTRANS); end
        n_checks++; if (HADDR !== 10'h000) begin n_errors++; $display("FAIL rm_haddr got %0h exp 0", HADDR); end
        n_checks++; if (HWRITE !== 1'b0) begin n_errors++; $display("FAIL rm_hwrite got %0b exp 0", HWRITE); end
        n_checks++; if (HSIZE !== 3'b000) begin n_errors++; $display("FAIL rm_hsize got %0h exp 0", HSIZE); end
        n_checks++; if (HWDATA !== 32'h0) begin n_errors++; $display("FAIL rm_hwdata got %0h exp 0", HWDATA); end
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL rm_rsp_valid got %0b exp 0", RSP_VALID); end
        n_checks++; if (RSP_RDATA !== 32'h0) begin n_errors++; $display("FAIL rm_rsp_rdata got %0h exp 0", RSP_RDATA); end
        n_checks++; if (RSP_ERROR !== 1'b0) begin n_errors++; $display("FAIL rm_rsp_error got %0b exp 0", RSP_ERROR); end
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_errors++; $display("FAIL rm_timeout got %0b exp 0", TIMEOUT_FLAG); end
        n_checks++; if (DBG_STATE !== 2'd0) begin n_errors++; $display("FAIL rm_state got %0d exp 0", DBG_STATE); end
        HRESETN = 1'b1;
        HREADY = 1'b1;
        tick();
        n_checks++; if (RSP_VALID !== 1'b0) begin n_errors++; $display("FAIL rm_release_rsp got %0b exp 0", RSP_VALID); end
        n_checks++; if (CMD_READY !== 1'b1) begin n_errors++; $display("FAIL rm_release_ready got %0b exp 1", CMD_READY); end
        drive_cmd(1'b1, 10'h002, 3'd1, 32'h0000_1357);
        tick();
        idle_cmd();
        n_checks++; if (HTRANS !== 2'b10) begin n_errors++; $display("FAIL rm_new_htrans got %0h exp 2", HTRANS); end
        tick();
        n_checks++; if (HWDATA !== 32'h0000_1357) begin n_errors++; $display("FAIL rm_new_hwdata got %0h exp 1357", HWDATA); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b1) begin n_errors++; $display("FAIL rm_new_rsp_valid got %0b exp 1", RSP_VALID); end
        n_checks++; if (RSP_ERROR !== 1'b0) begin n_errors++; $display("FAIL rm_new_rsp_error got %0b exp 0", RSP_ERROR); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_word_write();
        test_half_read_wait();
        test_misaligned();
        test_error_resp();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
